uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Frame-level controller sitting directly behind the UART receiver. It consumes the receiver's byte strobe, and sequences 5-byte command frames through a header/field/checksum state machine with an inter-byte timeout. It presents each validated frame as a single register-access command on a valid/ready handshake toward the register bank. Malformed, stalled or overrunning traffic is reported as one-cycle error events.

## Interface
- SOF, 8'h55: start-of-frame byte.
- TIMEOUT_CYC, 30000: max clk cycles allowed between consecutive bytes inside a frame (≈12 bit times at 2500 clk/bit).
- CNT_W, 15: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_byte  in  8  received byte; valid only in the rx_byte_vld cycle.
- rx_byte_vld  in  1  one-cycle strobe, one per received byte.
- cmd_valid  out  1  command available; held until accepted.
- cmd_ready  in  1  register bank accepts the command.
- cmd_wr  out  1  1 = write, 0 = read.
- cmd_addr  out  8  register address.
- cmd_wdata  out  8  write data (frame DATA byte; don't-care for reads).
- busy  out  1  high in any state other than IDLE.
- err_pulse  out  1  one-cycle error event.
- err_code  out  2  cause of last error: 0 overrun, 1 bad command, 2 checksum, 3 timeout; held until the next error.

## Operation
- Frame: SOF, CMD, ADDR, DATA, CHK. CMD is 8'h01 (write) or 8'h02 (read). CHK = CMD ^ ADDR ^ DATA.
- States: IDLE, CMD, ADDR, DATA, CHK, ISSUE.
- IDLE: on a byte equal to SOF, go to CMD. Any other byte is ignored silently, with no error.
- CMD: on 01/02, latch cmd_wr and go to ADDR. On any other value, raise error code 1 and go to IDLE.
- ADDR: on a byte, latch cmd_addr and go to DATA.
- DATA: on a byte, latch cmd_wdata and go to CHK.
- CHK: on a byte, compare it against the running XOR.
  - Match: go to ISSUE.
  - Mismatch: raise error code 2 and go to IDLE. cmd_* outputs are not updated.
- ISSUE: cmd_valid = 1. When cmd_valid & cmd_ready, go to IDLE.
  - Any byte arriving in ISSUE is dropped and raises error code 0, including in the same cycle as the handshake.
  - A dropped SOF does not start a frame.
- Timeout:
  - The counter clears on entry to CMD and on every accepted byte in CMD..CHK, and increments every other cycle in those states.
  - When the count reaches TIMEOUT_CYC-1 with no byte that cycle, raise error code 3 and go to IDLE.
  - If a byte arrives in the terminal-count cycle, the byte wins and no timeout is raised.
  - The counter is held at 0 in IDLE and ISSUE. ISSUE never times out.
- cmd_wr/cmd_addr/cmd_wdata stay stable while cmd_valid is high.

## Timing
- Reset values:
  - state IDLE.
  - cmd_valid, busy, err_pulse: 0.
  - cmd_wr, cmd_addr, cmd_wdata, err_code: 0.
  - Timeout counter and XOR accumulator: 0.
- All outputs are registered.
- cmd_valid rises the cycle after the CHK byte strobe, and falls the cycle after the handshake cycle.
- A byte strobe in the cycle immediately after the handshake is processed in IDLE, so back-to-back frames are supported.
- err_pulse is high exactly one cycle, the cycle after the causing strobe or terminal count. err_code updates in that same cycle.
- busy rises the cycle after the SOF strobe and falls with the return to IDLE.
- Reset mid-frame or mid-ISSUE: immediate return to reset values. The pending command is lost and no error is raised.

## Test plan
- Write frame 55 01 10 A5 B4, cmd_ready=1:
  - cmd_valid high exactly one cycle, one cycle after the B4 strobe.
  - cmd_wr=1, cmd_addr=10, cmd_wdata=A5.
  - No err_pulse.
- Read frame 55 02 20 00 22, cmd_ready held 0 for 5 cycles:
  - cmd_valid stays high with fields stable.
  - Accepted on the cycle ready rises; cmd_wr=0, cmd_addr=20.
- Bad frames:
  - 55 01 10 A5 00 → err_pulse with code 2, no cmd_valid.
  - 55 03 → err_pulse with code 1 one cycle after the 03 strobe.
  - A following good frame is accepted in both cases.
- Timeout: 55 01, then silence:
  - err_pulse with code 3 exactly TIMEOUT_CYC cycles after the 01 strobe.
  - A byte arriving on the terminal cycle yields no error.
- Overrun: during ISSUE with ready=0, send 55:
  - code 0 error, command still pending.
  - A subsequent full frame after the handshake is accepted normally.
- Garbage in IDLE (00 FF 12), then a valid frame: no errors, one command issued. Assert rst_n mid-ADDR: all outputs return to 0 immediately.

Source files
------------

// File: rtl/uart_cmd_parser.sv
//------------------------------------------------------------------------------
// Module      : uart_cmd_parser
// Description : Frames SOF/CMD/ADDR/DATA/CHK bytes from the UART receiver into
//               register-access commands with inter-byte timeout and error events.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_cmd_parser #(
  parameter logic [7:0] SOF         = 8'h55,
  parameter int         TIMEOUT_CYC = 30000,
  parameter int         CNT_W       = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_vld,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_wr,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       err_pulse,
  output logic [1:0] err_code
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CMD   = 3'd1;
  localparam logic [2:0] c_ADDR  = 3'd2;
  localparam logic [2:0] c_DATA  = 3'd3;
  localparam logic [2:0] c_CHK   = 3'd4;
  localparam logic [2:0] c_ISSUE = 3'd5;

  localparam logic [1:0] c_ERR_OVERRUN = 2'd0;
  localparam logic [1:0] c_ERR_BADCMD  = 2'd1;
  localparam logic [1:0] c_ERR_CHKSUM  = 2'd2;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

  localparam logic [CNT_W-1:0] c_CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_xor, w_xor_nxt;
  logic             r_wr, w_wr_nxt;
  logic [7:0]       r_addr, w_addr_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             w_err;
  logic [1:0]       w_err_cause;
  logic             w_cmd_load;
  logic             w_in_frame;
  logic             w_tmo;

  assign w_in_frame = (r_state >= c_CMD) && (r_state <= c_CHK);
  // A byte in the terminal-count cycle takes priority over the timeout.
  assign w_tmo      = w_in_frame && !rx_byte_vld && (r_cnt == c_CNT_TERM);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_xor     <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      cmd_valid <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      busy      <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_xor     <= w_xor_nxt;
      r_wr      <= w_wr_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      cmd_valid <= (w_state_nxt == c_ISSUE);
      busy      <= (w_state_nxt != c_IDLE);
      err_pulse <= w_err;
      if (w_err) begin
        err_code <= w_err_cause;
      end
      if (w_cmd_load) begin
        cmd_wr    <= r_wr;
        cmd_addr  <= r_addr;
        cmd_wdata <= r_data;
      end
    end
  end

  // Next-state and error detection
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_err_cause = c_ERR_OVERRUN;
    case (r_state)
      c_IDLE: begin
        if (rx_byte_vld && (rx_byte == SOF)) w_state_nxt = c_CMD;
      end
      c_CMD: begin
        if (rx_byte_vld) begin
          if ((rx_byte == 8'h01) || (rx_byte == 8'h02)) begin
            w_state_nxt = c_ADDR;
          end else begin
            w_state_nxt = c_IDLE;
            w_err       = 1'b1;
            w_err_cause = c_ERR_BADCMD;
          end
        end
      end
      c_ADDR: begin
        if (rx_byte_vld) w_state_nxt = c_DATA;
      end
      c_DATA: begin
        if (rx_byte_vld) w_state_nxt = c_CHK;
      end
      c_CHK: begin
        if (rx_byte_vld) begin
          if (rx_byte == r_xor) begin
            w_state_nxt = c_ISSUE;
          end else begin
            w_state_nxt = c_IDLE;
            w_err       = 1'b1;
            w_err_cause = c_ERR_CHKSUM;
          end
        end
      end
      c_ISSUE: begin
        if (rx_byte_vld) begin
          w_err       = 1'b1;
          w_err_cause = c_ERR_OVERRUN;
        end
        if (cmd_valid && cmd_ready) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
    if (w_tmo) begin
      w_state_nxt = c_IDLE;
      w_err       = 1'b1;
      w_err_cause = c_ERR_TIMEOUT;
    end
  end

  // Datapath: timeout counter, checksum accumulator, field capture
  always_comb begin
    w_cnt_nxt  = '0;
    w_xor_nxt  = r_xor;
    w_wr_nxt   = r_wr;
    w_addr_nxt = r_addr;
    w_data_nxt = r_data;
    w_cmd_load = 1'b0;
    if (w_in_frame && !rx_byte_vld && !w_tmo) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    case (r_state)
      c_IDLE: begin
        if (rx_byte_vld && (rx_byte == SOF)) w_xor_nxt = '0;
      end
      c_CMD: begin
        if (rx_byte_vld) begin
          w_wr_nxt  = (rx_byte == 8'h01);
          w_xor_nxt = r_xor ^ rx_byte;
        end
      end
      c_ADDR: begin
        if (rx_byte_vld) begin
          w_addr_nxt = rx_byte;
          w_xor_nxt  = r_xor ^ rx_byte;
        end
      end
      c_DATA: begin
        if (rx_byte_vld) begin
          w_data_nxt = rx_byte;
          w_xor_nxt  = r_xor ^ rx_byte;
        end
      end
      c_CHK: begin
        // Fields reach the command outputs only once the checksum matches.
        if (rx_byte_vld && (rx_byte == r_xor)) w_cmd_load = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_cmd_parser
// Description : Directed self-checking bench for uart_cmd_parser.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_cmd_parser;

  localparam int TIMEOUT_CYC = 20;
  localparam int CNT_W       = 5;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       busy;
  logic       err_pulse;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;
  int n_err_seen = 0;
  int n_acc = 0;

  uart_cmd_parser #(
    .SOF         (8'h55),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_byte     (rx_byte),
    .rx_byte_vld (rx_byte_vld),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .busy        (busy),
    .err_pulse   (err_pulse),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_pulse) n_err_seen++;
    if (cmd_valid && cmd_ready) n_acc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte     = b;
    rx_byte_vld = 1'b1;
    tick();
    rx_byte_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k);
    send(8'h55);
    send(c);
    send(a);
    send(d);
    send(k);
  endtask

  initial begin
    int e0;
    int a0;
    int lat;
    rst_n       = 1'b0;
    rx_byte     = 8'h00;
    rx_byte_vld = 1'b0;
    cmd_ready   = 1'b0;
    tick();
    tick();
    check("reset_outputs", {cmd_valid, busy, err_pulse, cmd_wr, cmd_addr, cmd_wdata, err_code}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Write frame, ready high
    cmd_ready = 1'b1;
    e0 = n_err_seen;
    send(8'h55);
    check("busy_after_sof", busy, 1);
    send(8'h01); send(8'h10); send(8'hA5);
    check("no_valid_before_chk", cmd_valid, 0);
    send(8'hB4);
    check("wr_valid", cmd_valid, 1);
    check("wr_fields", {cmd_wr, cmd_addr, cmd_wdata}, {1'b1, 8'h10, 8'hA5});
    tick();
    check("wr_valid_one_cycle", {cmd_valid, busy}, 2'b00);
    check("wr_no_err", n_err_seen - e0, 0);

    // Read frame, ready held low 5 cycles
    cmd_ready = 1'b0;
    send_frame(8'h02, 8'h20, 8'h00, 8'h22);
    for (int i = 0; i < 5; i++) begin
      check("rd_hold_valid", cmd_valid, 1);
      check("rd_hold_fields", {cmd_wr, cmd_addr, cmd_wdata}, {1'b0, 8'h20, 8'h00});
      tick();
    end
    a0 = n_acc;
    cmd_ready = 1'b1;
    tick();
    check("rd_accept_count", n_acc - a0, 1);
    check("rd_valid_drop", cmd_valid, 0);

    // Checksum error, then good frame
    send_frame(8'h01, 8'h10, 8'hA5, 8'h00);
    check("chk_err", {err_pulse, err_code, cmd_valid}, {1'b1, 2'd2, 1'b0});
    check("chk_fields_kept", {cmd_wr, cmd_addr, cmd_wdata}, {1'b0, 8'h20, 8'h00});
    tick();
    check("chk_err_one_cycle", err_pulse, 0);
    send_frame(8'h02, 8'h33, 8'h44, 8'h75);
    check("chk_recover", {cmd_valid, cmd_wr, cmd_addr, cmd_wdata}, {1'b1, 1'b0, 8'h33, 8'h44});
    tick();

    // Bad command, then good frame
    send(8'h55);
    send(8'h03);
    check("badcmd_err", {err_pulse, err_code, busy}, {1'b1, 2'd1, 1'b0});
    send_frame(8'h01, 8'h7F, 8'h01, 8'h7F);
    check("badcmd_recover", {cmd_valid, cmd_wr, cmd_addr, cmd_wdata}, {1'b1, 1'b1, 8'h7F, 8'h01});
    tick();

    // Timeout after CMD byte
    send(8'h55);
    send(8'h01);
    lat = 0;
    for (int k = 1; k <= TIMEOUT_CYC + 5; k++) begin
      if (lat == 0 && err_pulse) lat = k - 1;
      if (lat == 0) tick();
    end
    check("tmo_latency", lat, TIMEOUT_CYC);
    check("tmo_code", {err_code, busy}, {2'd3, 1'b0});
    tick();

    // Byte on the terminal-count cycle wins
    e0 = n_err_seen;
    send(8'h55);
    send(8'h01);
    for (int k = 1; k < TIMEOUT_CYC; k++) tick();
    send(8'h10);
    check("tmo_term_byte", {err_pulse, busy}, 2'b01);
    send(8'hA5);
    send(8'hB4);
    check("tmo_term_frame", {cmd_valid, cmd_addr}, {1'b1, 8'h10});
    check("tmo_term_no_err", n_err_seen - e0, 0);
    tick();

    // Overrun during ISSUE
    cmd_ready = 1'b0;
    send_frame(8'h01, 8'h10, 8'hA5, 8'hB4);
    send(8'h55);
    check("ovr_err", {err_pulse, err_code, cmd_valid, busy}, {1'b1, 2'd0, 1'b1, 1'b1});
    tick();
    check("ovr_pending", {err_pulse, cmd_valid}, 2'b01);
    rx_byte = 8'h55; rx_byte_vld = 1'b1; cmd_ready = 1'b1;
    tick();
    rx_byte_vld = 1'b0;
    check("ovr_handshake_drop", {err_pulse, cmd_valid, busy}, 3'b100);
    send_frame(8'h02, 8'h20, 8'h00, 8'h22);
    check("ovr_recover", {cmd_valid, cmd_wr, cmd_addr}, {1'b1, 1'b0, 8'h20});
    tick();

    // Garbage in IDLE, then a valid frame
    e0 = n_err_seen;
    a0 = n_acc;
    send(8'h00); send(8'hFF); send(8'h12);
    check("garbage_idle", busy, 0);
    send_frame(8'h01, 8'hAA, 8'h0F, 8'hA4);
    tick();
    check("garbage_no_err", n_err_seen - e0, 0);
    check("garbage_one_cmd", n_acc - a0, 1);

    // Asynchronous reset mid-ADDR
    send(8'h55);
    send(8'h01);
    rst_n = 1'b0;
    #1;
    check("rst_mid_frame", {cmd_valid, busy, err_pulse, cmd_wr, cmd_addr, cmd_wdata, err_code}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
